// File: rtl/repadd_pkg.sv
// ----------------------------------------------------------------------------
// repadd_pkg
//   Shared definitions for the repeated-addition multiplier.
//
//   Contents:
//     STATE_IDLE/RUN/DONE : raw state encodings. They are exposed so that
//                           external checkers can decode the state vector
//                           without importing the enum type.
//     state_e             : controller state enum built on those encodings.
//     umax / umin         : operand ordering helpers. On a tie, umax returns
//                           the first argument and umin the second.
// ----------------------------------------------------------------------------
package repadd_pkg;

  localparam logic [1:0] STATE_IDLE = 2'd0;
  localparam logic [1:0] STATE_RUN  = 2'd1;
  localparam logic [1:0] STATE_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = STATE_IDLE,
    RUN  = STATE_RUN,
    DONE = STATE_DONE
  } state_e;

  // Operand ordering helpers. Each is written for a 32-bit container. The
  // caller truncates the result back to the operand width.
  function automatic logic [31:0] umax(input logic [31:0] x, input logic [31:0] y);
    return (x >= y) ? x : y;
  endfunction

  function automatic logic [31:0] umin(input logic [31:0] x, input logic [31:0] y);
    return (x >= y) ? y : x;
  endfunction

endpackage

// File: rtl/repadd_cntr.sv
// ----------------------------------------------------------------------------
// repadd_cntr
//   Loadable down counter that holds the remaining number of additions.
//
//   Ports:
//     clk, rst_n : clock and asynchronous active-low reset (count clears to 0)
//     ld         : load ld_val. Load has priority over dec.
//     dec        : decrement by one
//     ld_val     : WIDTH-bit load value
//     eq1        : count is exactly 1 (the last addition is in progress)
//     eqz        : count is zero
// ----------------------------------------------------------------------------
module repadd_cntr #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld,
  input  logic             dec,
  input  logic [WIDTH-1:0] ld_val,
  output logic             eq1,
  output logic             eqz
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (ld) begin
      cnt_d = ld_val;
    end else if (dec) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign eq1 = (cnt_q == WIDTH'(1));
  assign eqz = (cnt_q == '0);

endmodule

// File: rtl/repadd_mul.sv
// ----------------------------------------------------------------------------
// repadd_mul
//   Unsigned multiplier that works by repeated addition. The larger operand is
//   added into the product register min(din_a, din_b) times. Keeping the
//   smaller operand as the iteration count keeps latency as low as possible.
//
//   Handshake: a request is taken when start is high at a rising edge while
//   the unit is in IDLE. busy stays high from the following cycle until done
//   has been shown. done is a one-cycle pulse. product and ovf are valid while
//   done is high, and they hold their values until the next accepted start.
//   A start that arrives while busy (RUN or DONE) is ignored.
//
//   Parameters:
//     WIDTH  : operand width (>= 2)
//     PROD_W : product register width, WIDTH..2*WIDTH
//
//   Ports:
//     clk, rst_n   : clock, asynchronous active-low reset
//     start        : request, sampled only in IDLE
//     din_a, din_b : operands, sampled together with an accepted start
//     busy         : high in RUN and DONE
//     done         : one-cycle completion pulse
//     product      : PROD_W-bit result (true product mod 2^PROD_W)
//     ovf          : sticky carry-out of the accumulation, valid with done
// ----------------------------------------------------------------------------
module repadd_mul
  import repadd_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int PROD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WIDTH-1:0]  din_a,
  input  logic [WIDTH-1:0]  din_b,
  output logic              busy,
  output logic              done,
  output logic [PROD_W-1:0] product,
  output logic              ovf
);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [PROD_W-1:0] product_q, product_d;
  logic              ovf_q, ovf_d;

  // Counter control
  logic              cnt_ld;
  logic              cnt_dec;
  logic [WIDTH-1:0]  cnt_ld_val;
  logic              cnt_eq1;
  logic              cnt_eqz;

  // Operand ordering. On a tie, the addend comes from din_a.
  logic [WIDTH-1:0]  op_max;
  logic [WIDTH-1:0]  op_min;

  // The accumulation adder is one bit wider than the product so that its MSB
  // is the carry that sets ovf.
  logic [PROD_W-1:0] a_ext;
  logic [PROD_W:0]   sum;

  assign op_max = WIDTH'(umax(32'(din_a), 32'(din_b)));
  assign op_min = WIDTH'(umin(32'(din_a), 32'(din_b)));

  assign a_ext  = PROD_W'(a_q);
  assign sum    = {1'b0, product_q} + {1'b0, a_ext};

  repadd_cntr #(
    .WIDTH (WIDTH)
  ) u_cntr (
    .clk    (clk),
    .rst_n  (rst_n),
    .ld     (cnt_ld),
    .dec    (cnt_dec),
    .ld_val (cnt_ld_val),
    .eq1    (cnt_eq1),
    .eqz    (cnt_eqz)
  );

  // Next-state and datapath control
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    product_d  = product_q;
    ovf_d      = ovf_q;
    cnt_ld     = 1'b0;
    cnt_dec    = 1'b0;
    cnt_ld_val = op_min;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d       = op_max;
          product_d = '0;
          ovf_d     = 1'b0;
          cnt_ld    = 1'b1;
          // A zero operand needs no additions. The product is already 0.
          state_d   = (op_min == '0) ? DONE : RUN;
        end
      end

      RUN: begin
        product_d = sum[PROD_W-1:0];
        if (sum[PROD_W]) begin
          ovf_d = 1'b1;
        end
        cnt_dec = 1'b1;
        // The count is loaded nonzero and leaves RUN at 1, so eqz is never
        // expected here. Checking it as well makes a corrupted count fall
        // out of RUN instead of wrapping through 2^WIDTH additions.
        if (cnt_eq1 || cnt_eqz) begin
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      product_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      product_q <= product_d;
      ovf_q     <= ovf_d;
    end
  end

  assign busy    = (state_q == RUN) || (state_q == DONE);
  assign done    = (state_q == DONE);
  assign product = product_q;
  assign ovf     = ovf_q;

endmodule
